hazard_forward_unit: RTL and testbench

Parametrised hazard, interlock and forwarding controller for the five-stage MIPS pipeline. It replaces the single-cycle, purely comparative forwarding logic with four things: registered forwarding selects, register-0 suppression, load-use interlock with configurable memory latency, and multi-cycle flush on branch/jump redirect. It also keeps saturating performance counters. It sits between the ID/EX, EX/MEM and MEM/WB interface registers and drives the stall and flush inputs of the PC and the IF/ID and ID/EX interfaces.

---
 rtl/hazard_forward_unit.sv | 191 +++++++++++++++++++
 tb/tb_hazard_forward_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard, interlock and forwarding controller for the five-stage MIPS pipeline.
// Produces registered forwarding selects for the EX stage, a load-use interlock
// stretched to the data-memory latency, a multi-cycle flush after redirects and
// saturating stall/flush performance counters. All state moves on the falling
// clock edge so it lines up with the pipeline interface registers.
module hazard_forward_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_LAT      = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  wb_reg_write,
  input  logic                  redirect,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  bubble_idex,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  // cnt counts the remaining extra cycles of the current stall or flush
  localparam logic [2:0] STALL_LOAD = 3'(MEM_LAT - 1);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t     state;
  state_t     nextState;
  logic [2:0] cnt;
  logic [2:0] nextCnt;

  logic       exWrites;
  logic       memWrites;
  logic       exHitRs;
  logic       exHitRt;
  logic       memHitRs;
  logic       memHitRt;
  logic       loadUse;
  logic       holdFront;
  logic       squashIdex;
  logic [1:0] selANext;
  logic [1:0] selBNext;
  logic       unusedWb;

  // Producer matches against the ID source fields; register 0 never matches
  always_comb begin
    exWrites  = ex_reg_write & (ex_dest != '0);
    memWrites = mem_reg_write & (mem_dest != '0);
    exHitRs   = exWrites & (ex_dest == id_rs);
    exHitRt   = exWrites & (ex_dest == id_rt);
    memHitRs  = memWrites & (mem_dest == id_rs);
    memHitRt  = memWrites & (mem_dest == id_rt);
    loadUse   = ex_mem_read & ((id_uses_rs & exHitRs) | (id_uses_rt & exHitRt));
    // MEM/WB producers are served by the write-before-read register file
    unusedWb  = ^{wb_dest, wb_reg_write};
  end

  // State register
  always_ff @(negedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Next-state logic: redirect takes priority over everything else
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    if (redirect) begin
      nextState = FLUSH;
      nextCnt   = FLUSH_LOAD;
    end else begin
      case (state)
        RUN: begin
          if (loadUse && (MEM_LAT > 1)) begin
            nextState = LSTALL;
            nextCnt   = STALL_LOAD;
          end
        end
        LSTALL, FLUSH: begin
          if (cnt <= 3'd1) begin
            nextState = RUN;
            nextCnt   = '0;
          end else begin
            nextCnt = cnt - 3'd1;
          end
        end
        default: begin
          nextState = RUN;
          nextCnt   = '0;
        end
      endcase
    end
  end

  // Output logic: stall is Mealy on the detection cycle, flush is Moore
  always_comb begin
    holdFront = 1'b0;
    if (!reset && !redirect) begin
      case (state)
        RUN:     holdFront = loadUse;
        LSTALL:  holdFront = 1'b1;
        default: holdFront = 1'b0;
      endcase
    end
    stall_pc    = holdFront;
    stall_ifid  = holdFront;
    bubble_idex = holdFront;
    flush_ifid  = (state == FLUSH);
    flush_idex  = (state == FLUSH);
    squashIdex  = holdFront | (state == FLUSH);
  end

  // Forwarding select for each operand: EX producer first, then EX/MEM
  always_comb begin
    selANext = SEL_RF;
    selBNext = SEL_RF;
    if (id_uses_rs) begin
      if (exHitRs) begin
        selANext = SEL_EXMEM;
      end else if (memHitRs) begin
        selANext = SEL_MEMWB;
      end
    end
    if (id_uses_rt) begin
      if (exHitRt) begin
        selBNext = SEL_EXMEM;
      end else if (memHitRt) begin
        selBNext = SEL_MEMWB;
      end
    end
  end

  // Selects latch alongside ID/EX; a bubble or flush entering EX reads the register file
  always_ff @(negedge clk) begin
    if (reset) begin
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
    end else if (squashIdex) begin
      fwd_a_sel <= SEL_RF;
      fwd_b_sel <= SEL_RF;
    end else begin
      fwd_a_sel <= selANext;
      fwd_b_sel <= selBNext;
    end
  end

  // Saturating performance counters
  always_ff @(negedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (holdFront && !(&stall_cycles)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (redirect && !(&flush_events)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: three parameterisations share one directed
// stimulus stream; a remaining-cycles model checks every cycle, literal
// expectations pin the test-plan scenarios.
module tb_hazard_forward_unit;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] idRs, idRt, exDest, memDest, wbDest;
  logic       usesRs, usesRt, exRw, exMr, memRw, wbRw, redirect;

  logic [1:0]  a0, b0, a1, b1, a2, b2;
  logic        sp0, si0, bu0, fi0, fx0;
  logic        sp1, si1, bu1, fi1, fx1;
  logic        sp2, si2, bu2, fi2, fx2;
  logic [15:0] sc0, fe0, sc1, fe1;
  logic [3:0]  sc2, fe2;

  hazard_forward_unit #(.REG_ADDR_W(5), .MEM_LAT(1), .FLUSH_CYCLES(2), .CNT_W(16)) u0 (
    .clk(clk), .reset(rst), .id_rs(idRs), .id_rt(idRt), .id_uses_rs(usesRs), .id_uses_rt(usesRt),
    .ex_dest(exDest), .ex_reg_write(exRw), .ex_mem_read(exMr), .mem_dest(memDest),
    .mem_reg_write(memRw), .wb_dest(wbDest), .wb_reg_write(wbRw), .redirect(redirect),
    .fwd_a_sel(a0), .fwd_b_sel(b0), .stall_pc(sp0), .stall_ifid(si0), .bubble_idex(bu0),
    .flush_ifid(fi0), .flush_idex(fx0), .stall_cycles(sc0), .flush_events(fe0));

  hazard_forward_unit #(.REG_ADDR_W(5), .MEM_LAT(3), .FLUSH_CYCLES(2), .CNT_W(16)) u1 (
    .clk(clk), .reset(rst), .id_rs(idRs), .id_rt(idRt), .id_uses_rs(usesRs), .id_uses_rt(usesRt),
    .ex_dest(exDest), .ex_reg_write(exRw), .ex_mem_read(exMr), .mem_dest(memDest),
    .mem_reg_write(memRw), .wb_dest(wbDest), .wb_reg_write(wbRw), .redirect(redirect),
    .fwd_a_sel(a1), .fwd_b_sel(b1), .stall_pc(sp1), .stall_ifid(si1), .bubble_idex(bu1),
    .flush_ifid(fi1), .flush_idex(fx1), .stall_cycles(sc1), .flush_events(fe1));

  hazard_forward_unit #(.REG_ADDR_W(5), .MEM_LAT(1), .FLUSH_CYCLES(3), .CNT_W(4)) u2 (
    .clk(clk), .reset(rst), .id_rs(idRs), .id_rt(idRt), .id_uses_rs(usesRs), .id_uses_rt(usesRt),
    .ex_dest(exDest), .ex_reg_write(exRw), .ex_mem_read(exMr), .mem_dest(memDest),
    .mem_reg_write(memRw), .wb_dest(wbDest), .wb_reg_write(wbRw), .redirect(redirect),
    .fwd_a_sel(a2), .fwd_b_sel(b2), .stall_pc(sp2), .stall_ifid(si2), .bubble_idex(bu2),
    .flush_ifid(fi2), .flush_idex(fx2), .stall_cycles(sc2), .flush_events(fe2));

  int vecCount = 0;
  int missCount = 0;
  bit cmpEn = 1'b0;

  // Model: per instance, the stall and flush cycles still owed after the current one
  int mlP[3]   = '{1, 3, 1};
  int fcP[3]   = '{2, 2, 3};
  int cmaxP[3] = '{65535, 65535, 15};
  int stallLeft[3] = '{0, 0, 0};
  int flushLeft[3] = '{0, 0, 0};
  int mSc[3] = '{0, 0, 0};
  int mFe[3] = '{0, 0, 0};
  int mA[3]  = '{0, 0, 0};
  int mB[3]  = '{0, 0, 0};

  function automatic bit luNow();
    return exMr && exRw && (exDest != 0) &&
           ((usesRs && idRs == exDest) || (usesRt && idRt == exDest));
  endfunction

  function automatic int srcSel(bit uses, logic [4:0] src);
    if (!uses) return 0;
    if (exRw && exDest != 0 && exDest == src) return 1;
    if (memRw && memDest != 0 && memDest == src) return 2;
    return 0;
  endfunction

  function automatic bit expStall(int i);
    return !rst && !redirect && (stallLeft[i] > 0 || (flushLeft[i] == 0 && luNow()));
  endfunction

  always @(negedge clk) begin : modelStep
    bit st, fl;
    for (int i = 0; i < 3; i++) begin
      st = expStall(i);
      fl = flushLeft[i] > 0;
      if (rst) begin
        stallLeft[i] = 0; flushLeft[i] = 0; mSc[i] = 0; mFe[i] = 0; mA[i] = 0; mB[i] = 0;
      end else begin
        if (st && mSc[i] < cmaxP[i]) mSc[i]++;
        if (redirect && mFe[i] < cmaxP[i]) mFe[i]++;
        mA[i] = (st || fl) ? 0 : srcSel(usesRs, idRs);
        mB[i] = (st || fl) ? 0 : srcSel(usesRt, idRt);
        if (redirect) begin
          flushLeft[i] = fcP[i];
          stallLeft[i] = 0;
        end else if (fl) begin
          flushLeft[i]--;
        end else if (stallLeft[i] > 0) begin
          stallLeft[i]--;
        end else if (luNow()) begin
          stallLeft[i] = mlP[i] - 1;
        end
      end
    end
  end

  task automatic cmpInst(input int i, input logic [40:0] act);
    logic [40:0] exp;
    bit st, fl;
    st = expStall(i);
    fl = flushLeft[i] > 0;
    exp = {2'(mA[i]), 2'(mB[i]), st, st, st, fl, fl, 16'(mSc[i]), 16'(mFe[i])};
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL cycle_u%0d t=%0t got=%h want=%h", i, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (cmpEn) begin
      cmpInst(0, {a0, b0, sp0, si0, bu0, fi0, fx0, sc0, fe0});
      cmpInst(1, {a1, b1, sp1, si1, bu1, fi1, fx1, sc1, fe1});
      cmpInst(2, {a2, b2, sp2, si2, bu2, fi2, fx2, 12'd0, sc2, 12'd0, fe2});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input bit ur, input bit ut,
                       input logic [4:0] ed, input bit erw, input bit emr,
                       input logic [4:0] md, input bit mrw, input bit rd);
    idRs = rs; idRt = rt; usesRs = ur; usesRt = ut;
    exDest = ed; exRw = erw; exMr = emr;
    memDest = md; memRw = mrw;
    wbDest = rs; wbRw = 1'b1;  // a matching MEM/WB producer must never select forwarding
    redirect = rd;
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
  endtask

  task automatic loadUseVec(input bit rd);
    drive(5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 5'd0, 0, rd);
  endtask

  initial begin
    rst = 1'b1;
    loadUseVec(0);
    step();
    cmpEn = 1'b1;
    loadUseVec(1);
    #1 chk("rst_stall_forced", sp1, 0);
    step();
    chk("rst_sc", sc0, 0);
    chk("rst_fe", fe0, 0);
    chk("rst_sel", {a0, b0}, 0);
    chk("rst_flush", fi0, 0);
    rst = 1'b0;

    // add r3,r1,r2 then sub r4,r3,r1
    drive(5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0); step();
    drive(5'd3, 5'd1, 1, 1, 5'd3, 1, 0, 5'd0, 0, 0);
    #1 chk("alu_nostall", sp0, 0);
    step();
    chk("fwd_exmem_a", a0, 1);
    chk("fwd_exmem_b", b0, 0);
    drive(5'd3, 5'd1, 1, 1, 5'd0, 0, 0, 5'd3, 1, 0); step();
    chk("fwd_memwb_a", a0, 2);
    chk("fwd_memwb_b", b0, 0);
    drive(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 5'd0, 1, 0); step();
    chk("r0_sel", {a0, b0}, 0);
    drive(5'd7, 5'd7, 1, 1, 5'd7, 1, 0, 5'd7, 1, 0); step();
    chk("ex_before_mem", {a0, b0}, 4'b0101);
    drive(5'd7, 5'd7, 0, 0, 5'd7, 1, 0, 5'd7, 1, 0); step();
    chk("unused_src", {a0, b0}, 0);

    // lw r5 then add r6,r5,r5
    loadUseVec(0);
    #1 chk("lu_stall_pc", sp0, 1);
    chk("lu_stall_ifid", si0, 1);
    chk("lu_bubble", bu0, 1);
    step();
    chk("lu_sel_bubble", {a0, b0}, 0);
    drive(5'd5, 5'd5, 1, 1, 5'd0, 0, 0, 5'd5, 1, 0);
    #1 chk("lu_ml1_done", sp0, 0);
    chk("lu_ml3_hold", sp1, 1);
    step();
    chk("lu_sel_ml1", {a0, b0}, 4'b1010);
    chk("lu_sel_ml3_bubble", {a1, b1}, 0);
    step();
    chk("ml3_cycles", sc1, 3);
    chk("ml1_cycles", sc0, 1);
    chk("ml3_stall_end", sp1, 0);
    step();
    chk("lu_sel_ml3", {a1, b1}, 4'b1010);

    // redirect coinciding with load-use
    loadUseVec(1);
    #1 chk("redir_no_stall", sp0, 0);
    step();
    chk("flush1_ifid", fi0, 1);
    chk("flush1_idex", fx0, 1);
    chk("fe_count", fe0, 1);
    loadUseVec(0);
    #1 chk("flush_masks_lu", sp0, 0);
    step();
    chk("flush2", fi0, 1);
    idle(); step();
    chk("flush_end", fi0, 0);
    chk("fe_hold", fe0, 1);
    chk("sc_after_flush", sc0, 1);

    // reset during the second LSTALL cycle
    loadUseVec(0); step();
    drive(5'd5, 5'd5, 1, 1, 5'd0, 0, 0, 5'd5, 1, 0); step();
    chk("lstall2", sp1, 1);
    rst = 1'b1; step();
    rst = 1'b0;
    #1 chk("rst_mid_stall", sp1, 0);
    chk("rst_mid_sc", sc1, 0);
    chk("rst_mid_fe", fe1, 0);
    chk("rst_mid_sel", {a1, b1}, 0);
    chk("rst_mid_flush", fi1, 0);
    step();
    chk("rst_no_residual", sp1, 0);

    // 20 consecutive stall cycles
    loadUseVec(0);
    repeat (20) step();
    chk("sat_cnt4", sc2, 15);
    chk("cnt16_20", sc0, 20);
    chk("ml3_continuous", sc1, 20);

    // redirect aborts LSTALL, repeated redirect reloads the flush
    idle(); step();
    loadUseVec(0); step();
    loadUseVec(1);
    #1 chk("redir_in_lstall", sp1, 0);
    step();
    chk("abort_to_flush", fi1, 1);
    drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1); step();
    idle(); step();
    chk("reload_hold", fi1, 1);
    step();
    chk("reload_end", fi1, 0);
    chk("fe_two", fe1, 2);

    // mixed traffic over a small register range
    repeat (300) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
      rst = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    step();
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
